// File: rtl/card_pkg.sv
// Shared card-grid constants for the selection controller and the display.
// The display's card_valid logic must use these same constants so that the
// highlighted cards and the hit-test always agree.
package card_pkg;

  localparam logic [5:0] NO_CARD = 6'd63;
  localparam int         ROWS    = 8;
  localparam int         COLS    = 18;
  localparam int         SLOTS   = 144;

  localparam logic [9:0] GRID_X0 = 10'd32;
  localparam logic [9:0] GRID_X1 = 10'd607;
  localparam logic [9:0] COL_W   = 10'd32;

  // Row spans are inclusive start, exclusive end; index 0 is the top row.
  localparam logic [ROWS-1:0][9:0] ROW_Y0 = {
    10'd415, 10'd360, 10'd294, 10'd239, 10'd184, 10'd129, 10'd74, 10'd19
  };
  localparam logic [ROWS-1:0][9:0] ROW_Y1 = {
    10'd461, 10'd406, 10'd340, 10'd285, 10'd230, 10'd175, 10'd120, 10'd65
  };

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HIT     = 3'd1,
    ST_CHECK   = 3'd2,
    ST_UPDATE  = 3'd3,
    ST_RELEASE = 3'd4
  } sel_state_e;

  // Flat slot index of a grid cell: row-major, 18 slots per row.
  function automatic logic [7:0] slot_idx(input logic [2:0] row, input logic [4:0] col);
    return 8'(row) * 8'd18 + 8'(col);
  endfunction

endpackage

// File: rtl/card_hit_decode.sv
// Combinational pointer-to-slot decoder for the fixed 8x18 card grid.
// A position outside every column or row span reports hit = 0.
module card_hit_decode
  import card_pkg::*;
(
  input  logic [9:0] x,
  input  logic [9:0] y,
  output logic       hit,
  output logic [2:0] row,
  output logic [4:0] col,
  output logic [7:0] idx
);

  logic            col_hit_s;
  logic [ROWS-1:0] row_match_s;

  // Column/row span tests; columns are 32 pixels wide, so col is a shift.
  always_comb begin
    row_match_s = '0;
    row         = 3'd0;
    col_hit_s   = (x >= GRID_X0) && (x < GRID_X1);
    for (int r = 0; r < ROWS; r++) begin
      row_match_s[r] = (y >= ROW_Y0[r]) && (y < ROW_Y1[r]);
      row            = row_match_s[r] ? 3'(r) : row;
    end
    col = col_hit_s ? 5'((x - GRID_X0) >> 3'd5) : 5'd0;
    hit = col_hit_s && (|row_match_s);
    idx = slot_idx(row, col);
  end

endmodule

// File: rtl/card_select_ctrl.sv
// Mouse-click to card-selection-mask controller.
// IDLE -> HIT -> CHECK -> UPDATE -> RELEASE; the toggle is committed on the
// edge that leaves UPDATE, three cycles after the sampled button rise.
// Build option: define CARD_SEL_HAND_ONLY_EN to restrict selection to rows 6-7.
module card_select_ctrl
  import card_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter logic [7:0]  MAX_SEL         = 8'd144
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         interboard_rst,
  input  logic         en,
  input  logic         clear_sel,
  input  logic [9:0]   mouse_x,
  input  logic [9:0]   mouse_y,
  input  logic         mouse_left,
  input  logic [863:0] map,
  output logic [143:0] sel_card,
  output logic [7:0]   sel_cnt,
  output logic         click_pulse,
  output logic [7:0]   click_idx,
  output logic         busy
);

  localparam int unsigned     DB_W   = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_END = DB_W'(DEBOUNCE_CYCLES - 1);

  sel_state_e     state_r, state_nx_s;
  logic           left_d_r;
  logic [9:0]     x_r, y_r;
  logic [7:0]     idx_r;
  logic           dec_hit_s;
  logic [2:0]     dec_row_s;
  logic [4:0]     dec_col_s;
  logic [7:0]     dec_idx_s;
  logic           hit_ok_s;
  logic [5:0]     code_s;
  logic [DB_W-1:0] db_cnt_r;
  logic [143:0]   sel_card_r;
  logic [7:0]     sel_cnt_r;
  logic [7:0]     click_idx_r;
  logic           click_pulse_r;
  logic           busy_r;

  card_hit_decode u_hit_decode (
    .x   (x_r),
    .y   (y_r),
    .hit (dec_hit_s),
    .row (dec_row_s),
    .col (dec_col_s),
    .idx (dec_idx_s)
  );

  assign code_s = map[10'(idx_r) * 10'd6 +: 6];

  // Qualify the decoded hit: cross-check index against row/col, optional row filter.
  always_comb begin
    hit_ok_s = 1'b0;
    if (dec_hit_s && (dec_idx_s == slot_idx(dec_row_s, dec_col_s))) begin
`ifdef CARD_SEL_HAND_ONLY_EN
      hit_ok_s = (dec_row_s >= 3'd6);
`else
      hit_ok_s = 1'b1;
`endif
    end else begin
      hit_ok_s = 1'b0;
    end
  end

  // Next-state decision for the click transaction.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (en && mouse_left && !left_d_r) state_nx_s = ST_HIT;
        else                               state_nx_s = ST_IDLE;
      end
      ST_HIT: begin
        if (hit_ok_s) state_nx_s = ST_CHECK;
        else          state_nx_s = ST_RELEASE;
      end
      ST_CHECK: begin
        if (code_s == NO_CARD)          state_nx_s = ST_RELEASE;
        else if (sel_card_r[idx_r])     state_nx_s = ST_UPDATE;
        else if (sel_cnt_r < MAX_SEL)   state_nx_s = ST_UPDATE;
        else                            state_nx_s = ST_RELEASE;
      end
      ST_UPDATE: state_nx_s = ST_RELEASE;
      ST_RELEASE: begin
        if (!mouse_left && (db_cnt_r == DB_END)) state_nx_s = ST_IDLE;
        else                                     state_nx_s = ST_RELEASE;
      end
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // State register, button history and busy flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r  <= ST_IDLE;
      left_d_r <= 1'b0;
      busy_r   <= 1'b0;
    end else if (interboard_rst) begin
      state_r  <= ST_IDLE;
      left_d_r <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      state_r  <= state_nx_s;
      left_d_r <= mouse_left;
      busy_r   <= (state_nx_s != ST_IDLE);
    end
  end

  // Latch the pointer on the accepted press and the decoded slot in HIT.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_r   <= 10'd0;
      y_r   <= 10'd0;
      idx_r <= 8'd0;
    end else if (interboard_rst) begin
      x_r   <= 10'd0;
      y_r   <= 10'd0;
      idx_r <= 8'd0;
    end else begin
      if ((state_r == ST_IDLE) && (state_nx_s == ST_HIT)) begin
        x_r <= mouse_x;
        y_r <= mouse_y;
      end
      if (state_r == ST_HIT) begin
        idx_r <= dec_idx_s;
      end
    end
  end

  // Selection mask and count; clear_sel overrides a same-cycle toggle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sel_card_r    <= 144'd0;
      sel_cnt_r     <= 8'd0;
      click_pulse_r <= 1'b0;
      click_idx_r   <= 8'd0;
    end else if (interboard_rst) begin
      sel_card_r    <= 144'd0;
      sel_cnt_r     <= 8'd0;
      click_pulse_r <= 1'b0;
      click_idx_r   <= 8'd0;
    end else begin
      click_pulse_r <= 1'b0;
      if (clear_sel) begin
        sel_card_r <= 144'd0;
        sel_cnt_r  <= 8'd0;
      end else if (state_r == ST_UPDATE) begin
        if (sel_card_r[idx_r]) begin
          sel_card_r[idx_r] <= 1'b0;
          click_pulse_r     <= 1'b1;
          click_idx_r       <= idx_r;
          if (sel_cnt_r != 8'd0) sel_cnt_r <= sel_cnt_r - 8'd1;
        end else if (sel_cnt_r < MAX_SEL) begin
          sel_card_r[idx_r] <= 1'b1;
          click_pulse_r     <= 1'b1;
          click_idx_r       <= idx_r;
          sel_cnt_r         <= sel_cnt_r + 8'd1;
        end
      end
    end
  end

  // Release debounce: count consecutive low cycles, restart on any high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      db_cnt_r <= '0;
    end else if (interboard_rst) begin
      db_cnt_r <= '0;
    end else if ((state_r != ST_RELEASE) || mouse_left) begin
      db_cnt_r <= '0;
    end else if (db_cnt_r == DB_END) begin
      db_cnt_r <= '0;
    end else begin
      db_cnt_r <= db_cnt_r + DB_W'(1);
    end
  end

  assign sel_card    = sel_card_r;
  assign sel_cnt     = sel_cnt_r;
  assign click_pulse = click_pulse_r;
  assign click_idx   = click_idx_r;
  assign busy        = busy_r;

endmodule

// File: tb/tb_card_select_ctrl.sv
// Directed bench for card_select_ctrl (DEBOUNCE_CYCLES=16, MAX_SEL=2).
module tb_card_select_ctrl;

`ifdef CARD_SEL_HAND_ONLY_EN
  localparam bit HAND = 1'b1;
`else
  localparam bit HAND = 1'b0;
`endif
  localparam int MAXS = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         interboard_rst;
  logic         en;
  logic         clear_sel;
  logic [9:0]   mouse_x;
  logic [9:0]   mouse_y;
  logic         mouse_left;
  logic [863:0] map_v;
  logic [143:0] sel_card;
  logic [7:0]   sel_cnt;
  logic         click_pulse;
  logic [7:0]   click_idx;
  logic         busy;

  always #5 clk = ~clk;

  card_select_ctrl #(.DEBOUNCE_CYCLES(16), .MAX_SEL(8'd2)) dut (
    .clk            (clk),
    .rst            (rst),
    .interboard_rst (interboard_rst),
    .en             (en),
    .clear_sel      (clear_sel),
    .mouse_x        (mouse_x),
    .mouse_y        (mouse_y),
    .mouse_left     (mouse_left),
    .map            (map_v),
    .sel_card       (sel_card),
    .sel_cnt        (sel_cnt),
    .click_pulse    (click_pulse),
    .click_idx      (click_idx),
    .busy           (busy)
  );

  typedef struct {
    logic [9:0] x;
    logic [9:0] y;
    logic       en_v;
    logic       drop;
    logic       hit;
    logic [7:0] idx;
  } vec_t;

  vec_t         vecs [17];
  int           tests  = 0;
  int           failed = 0;
  logic [143:0] exp_mask;
  int           exp_cnt;

  task automatic check(input string name, input logic [143:0] act, input logic [143:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model of one committed click; ok = a toggle is expected.
  task automatic model_step(input logic en_v, input logic hit, input logic [7:0] idx, output logic ok);
    ok = 1'b0;
    if (en_v && hit && (!HAND || idx >= 8'd108) && map_v[int'(idx)*6 +: 6] != 6'd63) begin
      if (exp_mask[idx]) begin
        ok = 1'b1; exp_mask[idx] = 1'b0; exp_cnt--;
      end else if (exp_cnt < MAXS) begin
        ok = 1'b1; exp_mask[idx] = 1'b1; exp_cnt++;
      end
    end
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy === 1'b1 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    check(name, 144'(busy), 144'd0);
  endtask

  // Press, sample three cycles after the accepting edge, release, debounce.
  task automatic click_run(input logic [9:0] x, input logic [9:0] y, input logic en_v,
                           input logic drop, output logic [2:0] pulses,
                           output logic busy1, output logic [7:0] idx_seen);
    @(negedge clk);
    en = en_v; mouse_x = x; mouse_y = y; mouse_left = 1'b1;
    @(posedge clk);
    pulses = 3'b000;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      pulses[k-1] = click_pulse;
      if (k == 1) begin
        busy1 = busy;
        if (drop) en = 1'b0;
      end
    end
    idx_seen = click_idx;
    @(negedge clk); mouse_left = 1'b0;
    wait_idle("idle after click");
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [2:0] pulses;
    logic       busy1, ok, early;
    logic [7:0] idx_seen;
    logic [5:0] bpat;
    int         pc;

    vecs[0]  = '{10'd40,  10'd20,  1'b1, 1'b0, 1'b1, 8'd0};
    vecs[1]  = '{10'd40,  10'd20,  1'b1, 1'b0, 1'b1, 8'd0};
    vecs[2]  = '{10'd40,  10'd340, 1'b1, 1'b0, 1'b0, 8'd0};
    vecs[3]  = '{10'd40,  10'd359, 1'b1, 1'b0, 1'b0, 8'd0};
    vecs[4]  = '{10'd606, 10'd360, 1'b1, 1'b0, 1'b1, 8'd125};
    vecs[5]  = '{10'd607, 10'd360, 1'b1, 1'b0, 1'b0, 8'd0};
    vecs[6]  = '{10'd31,  10'd100, 1'b1, 1'b0, 1'b0, 8'd0};
    vecs[7]  = '{10'd192, 10'd74,  1'b1, 1'b1, 1'b1, 8'd23};
    vecs[8]  = '{10'd96,  10'd100, 1'b1, 1'b0, 1'b1, 8'd20};
    vecs[9]  = '{10'd40,  10'd20,  1'b1, 1'b0, 1'b1, 8'd0};
    vecs[10] = '{10'd606, 10'd405, 1'b1, 1'b0, 1'b1, 8'd125};
    vecs[11] = '{10'd40,  10'd20,  1'b0, 1'b0, 1'b1, 8'd0};
    vecs[12] = '{10'd40,  10'd20,  1'b1, 1'b0, 1'b1, 8'd0};
    vecs[13] = '{10'd100, 10'd461, 1'b1, 1'b0, 1'b0, 8'd0};
    vecs[14] = '{10'd32,  10'd420, 1'b1, 1'b0, 1'b1, 8'd126};
    vecs[15] = '{10'd192, 10'd74,  1'b1, 1'b0, 1'b1, 8'd23};
    vecs[16] = '{10'd32,  10'd420, 1'b1, 1'b0, 1'b1, 8'd126};

    for (int i = 0; i < 144; i++) map_v[i*6 +: 6] = 6'd5;
    map_v[20*6 +: 6] = 6'd63;
    exp_mask = '0; exp_cnt = 0;

    rst = 1'b0; interboard_rst = 1'b0; en = 1'b0; clear_sel = 1'b0;
    mouse_x = 10'd0; mouse_y = 10'd0; mouse_left = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset sel_card", sel_card, 144'd0);
    check("reset sel_cnt", 144'(sel_cnt), 144'd0);
    check("reset click_pulse", 144'(click_pulse), 144'd0);
    check("reset click_idx", 144'(click_idx), 144'd0);
    check("reset busy", 144'(busy), 144'd0);
    @(negedge clk); rst = 1'b1;

    for (int i = 0; i < 17; i++) begin
      click_run(vecs[i].x, vecs[i].y, vecs[i].en_v, vecs[i].drop, pulses, busy1, idx_seen);
      model_step(vecs[i].en_v, vecs[i].hit, vecs[i].idx, ok);
      check($sformatf("vec%0d pulse timing", i), 144'(pulses), ok ? 144'd4 : 144'd0);
      check($sformatf("vec%0d busy", i), 144'(busy1), 144'(vecs[i].en_v));
      if (ok) check($sformatf("vec%0d click_idx", i), 144'(idx_seen), 144'(vecs[i].idx));
      check($sformatf("vec%0d sel_card", i), sel_card, exp_mask);
      check($sformatf("vec%0d sel_cnt", i), 144'(sel_cnt), 144'(exp_cnt));
    end

    // Held press with release bounce: one toggle, then exactly 16 low cycles.
    @(negedge clk);
    en = 1'b1; mouse_x = 10'd32; mouse_y = 10'd420; mouse_left = 1'b1; pc = 0;
    repeat (50) begin
      @(posedge clk); #1;
      if (click_pulse) pc++;
    end
    bpat = 6'b101000;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk); mouse_left = bpat[j];
      @(posedge clk); #1;
      if (click_pulse) pc++;
    end
    @(negedge clk); mouse_left = 1'b0; early = 1'b0;
    for (int j = 0; j < 15; j++) begin
      @(posedge clk); #1;
      if (!busy) early = 1'b1;
      if (click_pulse) pc++;
    end
    check("debounce busy before 16 lows", 144'(early), 144'd0);
    @(posedge clk); #1;
    check("debounce idle after 16 lows", 144'(busy), 144'd0);
    model_step(1'b1, 1'b1, 8'd126, ok);
    check("bounce single toggle", 144'(pc), ok ? 144'd1 : 144'd0);
    check("bounce sel_card", sel_card, exp_mask);

    // clear_sel during UPDATE wins over the toggle.
    @(negedge clk);
    mouse_x = 10'd64; mouse_y = 10'd420; mouse_left = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); clear_sel = 1'b1;
    @(posedge clk); #1;
    check("clear in UPDATE pulse", 144'(click_pulse), 144'd0);
    check("clear in UPDATE sel_card", sel_card, 144'd0);
    check("clear in UPDATE sel_cnt", 144'(sel_cnt), 144'd0);
    check("clear in UPDATE to RELEASE", 144'(busy), 144'd1);
    @(negedge clk); clear_sel = 1'b0; mouse_left = 1'b0;
    wait_idle("idle after clear");
    exp_mask = '0; exp_cnt = 0;

    // Reset while in CHECK.
    click_run(10'd64, 10'd420, 1'b1, 1'b0, pulses, busy1, idx_seen);
    model_step(1'b1, 1'b1, 8'd127, ok);
    check("pre-reset sel_card", sel_card, exp_mask);
    @(negedge clk); mouse_x = 10'd32; mouse_y = 10'd420; mouse_left = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0; #1;
    check("rst in CHECK busy", 144'(busy), 144'd0);
    check("rst in CHECK sel_card", sel_card, 144'd0);
    check("rst in CHECK sel_cnt", 144'(sel_cnt), 144'd0);
    check("rst in CHECK click_idx", 144'(click_idx), 144'd0);
    check("rst in CHECK click_pulse", 144'(click_pulse), 144'd0);
    mouse_left = 1'b0;
    @(negedge clk); rst = 1'b1;
    exp_mask = '0; exp_cnt = 0;

    click_run(10'd64, 10'd420, 1'b1, 1'b0, pulses, busy1, idx_seen);
    model_step(1'b1, 1'b1, 8'd127, ok);
    check("post-reset pulse", 144'(pulses), ok ? 144'd4 : 144'd0);
    check("post-reset sel_cnt", 144'(sel_cnt), 144'(exp_cnt));

    // Peer-board synchronous clear.
    @(negedge clk); interboard_rst = 1'b1;
    @(posedge clk); #1;
    check("interboard sel_card", sel_card, 144'd0);
    check("interboard sel_cnt", 144'(sel_cnt), 144'd0);
    @(negedge clk); interboard_rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
